// File: rtl/data_register.sv
// Parameterised holding register: asynchronous reset, synchronous clear, load enable.
// The reset port keeps the historical name rst_n but is active-high.
module data_register #(
    parameter int              WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear outranks enable, so a cleared word is never overwritten on the same edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_data_register.sv
// Self-checking bench for data_register: directed scenarios followed by
// randomized traffic against a rule-level reference model.
module tb_data_register;

    localparam int          WIDTH   = 16;
    localparam logic [15:0] RST_VAL = 16'h0000;
    localparam logic [15:0] CLR_VAL = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [15:0] d;
    logic [15:0] q;

    logic [15:0] model_q;
    int          tests;
    int          fails;

    data_register #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL),
        .CLR_VAL (CLR_VAL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .d     (d),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: q=%h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what the register must hold after the coming rising edge,
    // given the inputs presented now.
    task automatic tick();
        if (rst_n)
            model_q = RST_VAL;
        else if (clr)
            model_q = CLR_VAL;
        else if (en)
            model_q = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b1;
        en      = 1'b0;
        clr     = 1'b0;
        d       = 16'h0000;
        model_q = RST_VAL;

        // 1: reset held for two cycles, then released
        #1;
        chk("reset_async", q, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_hold", q, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_release", q, 16'h0000);

        // 2: enable gating
        d  = 16'd88;
        en = 1'b0;
        tick();
        chk("en_gate", q, 16'h0000);

        // 3: load, visible only after the edge
        @(negedge clk);
        en = 1'b1;
        d  = 16'd168;
        #1;
        chk("load_not_before", q, 16'h0000);
        tick();
        chk("load_168", q, 16'd168);

        // 4: clear beats enable; clear works without enable
        @(negedge clk);
        clr = 1'b1;
        tick();
        chk("clr_over_en", q, 16'h0000);
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b0;
        d   = 16'h5A5A;
        en  = 1'b1;
        tick();
        chk("reload", q, 16'h5A5A);
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b1;
        d   = 16'd168;
        tick();
        chk("clr_no_en", q, 16'h0000);

        // 5: hold with en low while d toggles
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b1;
        d   = 16'hBEEF;
        tick();
        chk("load_beef", q, 16'hBEEF);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d = ~d;
            tick();
            chk("hold_beef", q, 16'hBEEF);
        end

        // 6: mid-cycle reset, then recovery
        @(negedge clk);
        en = 1'b1;
        d  = 16'hFFFF;
        tick();
        chk("load_ffff", q, 16'hFFFF);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        model_q = RST_VAL;
        #1;
        chk("rst_mid_cycle", q, 16'h0000);
        #2;
        rst_n = 1'b0;
        en    = 1'b1;
        d     = 16'h1234;
        #1;
        chk("rst_released_hold", q, 16'h0000);
        tick();
        chk("after_rst_load", q, 16'h1234);

        // Reset held across an edge overrides clr and en
        @(negedge clk);
        rst_n = 1'b1;
        clr   = 1'b1;
        en    = 1'b1;
        d     = 16'h7777;
        tick();
        chk("rst_over_edge", q, 16'h0000);
        @(negedge clk);
        rst_n = 1'b0;
        clr   = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            en  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            d   = 16'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                rst_n   = 1'b1;
                model_q = RST_VAL;
                #1;
                chk("rnd_async_rst", q, model_q);
                if ($urandom_range(0, 1) == 0) begin
                    #1;
                    rst_n = 1'b0;
                end
            end else begin
                rst_n = 1'b0;
            end
            tick();
            chk("rnd", q, model_q);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
